// File: rtl/l2_l1_responder_if.sv
// l2_l1_responder_if: L1 miss-interface and memory-port signal bundle
interface l2_l1_responder_if #(parameter int LINE_W = 128, parameter int ADDR_W = 26);
  logic read_L1_L2;
  logic write_L1_L2;
  logic [4:0] index_L1_L2;
  logic [ADDR_W-6:0] tag_L1_L2;
  logic [ADDR_W-6:0] write_tag_L1_L2;
  logic [LINE_W-1:0] data_L1_L2;
  logic ready_L2_L1;
  logic [LINE_W-1:0] data_L2_L1;
  logic mem_req;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic mem_ready;
  modport slave (
    input read_L1_L2, write_L1_L2, index_L1_L2, tag_L1_L2, write_tag_L1_L2, data_L1_L2, mem_rdata, mem_ready,
    output ready_L2_L1, data_L2_L1, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output read_L1_L2, write_L1_L2, index_L1_L2, tag_L1_L2, write_tag_L1_L2, data_L1_L2, mem_rdata, mem_ready,
    input ready_L2_L1, data_L2_L1, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l2_l1_responder.sv
// l2_l1_responder: direct-mapped write-back L2 serving L1 refills/write-backs; L2_STAT_EN adds hit/miss counters
module l2_l1_responder #(
  parameter int LINE_W = 128,
  parameter int L2_IDX_W = 7,
  parameter int ADDR_W = 26
) (
  input logic clk,
  input logic rst,
  l2_l1_responder_if.slave bus
`ifdef L2_STAT_EN
  ,
  output logic [31:0] stat_hit,
  output logic [31:0] stat_miss
`endif
);
  localparam int TW = ADDR_W - L2_IDX_W;
  localparam int N = 2 ** L2_IDX_W;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOOKUP = 3'd1, S_EVICT = 3'd2, S_FILL = 3'd3, S_RESP = 3'd4, S_HOLD = 3'd5;
  logic [2:0] state;
  logic op_wr;
  logic [ADDR_W-1:0] a;
  logic [LINE_W-1:0] req_line;
  logic [LINE_W-1:0] line_mem [N];
  logic [TW-1:0] tag_mem [N];
  logic [N-1:0] valid, dirty;
  logic [L2_IDX_W-1:0] set;
  logic [TW-1:0] atag;
  logic hit, victim_dirty, hit_wr, l1_install, fill_done, st_we;
  logic [LINE_W-1:0] st_line;
  assign set = a[L2_IDX_W-1:0];
  assign atag = a[ADDR_W-1:L2_IDX_W];
  assign hit = valid[set] && tag_mem[set] == atag;
  assign victim_dirty = valid[set] && dirty[set];
  assign bus.ready_L2_L1 = state == S_RESP;
  // Line-store write enables: write hit, L1 line install, or memory fill; nothing lands during reset
  always_comb begin
    hit_wr = state == S_LOOKUP && hit && op_wr;
    l1_install = op_wr && ((state == S_LOOKUP && !hit && !victim_dirty) || (state == S_EVICT && bus.mem_req && bus.mem_ready));
    fill_done = state == S_FILL && bus.mem_req && bus.mem_ready;
    st_we = !rst && (hit_wr || l1_install || fill_done);
    st_line = fill_done ? bus.mem_rdata : req_line;
  end
  // Data and tag arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (st_we) begin
      line_mem[set] <= st_line;
      tag_mem[set] <= atag;
    end
  end
  // Transaction FSM; each memory request is raised on the first cycle of its state so mem_req
  // always drops for a cycle after mem_ready, even between an eviction and the following fill
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_wr <= 1'b0;
      a <= '0;
      req_line <= '0;
      valid <= '0;
      dirty <= '0;
      bus.data_L2_L1 <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.read_L1_L2 || bus.write_L1_L2) begin
          op_wr <= bus.write_L1_L2;
          a <= bus.write_L1_L2 ? {bus.write_tag_L1_L2, bus.index_L1_L2} : {bus.tag_L1_L2, bus.index_L1_L2};
          req_line <= bus.data_L1_L2;
          state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (hit_wr) dirty[set] <= 1'b1;
          if (hit && !op_wr) bus.data_L2_L1 <= line_mem[set];
          if (l1_install) begin
            valid[set] <= 1'b1;
            dirty[set] <= 1'b1;
          end
          state <= hit || l1_install ? S_RESP : victim_dirty ? S_EVICT : S_FILL;
        end
        S_EVICT: if (!bus.mem_req) begin
          bus.mem_req <= 1'b1;
          bus.mem_we <= 1'b1;
          bus.mem_addr <= {tag_mem[set], set};
          bus.mem_wdata <= line_mem[set];
        end else if (bus.mem_ready) begin
          bus.mem_req <= 1'b0;
          dirty[set] <= op_wr;
          if (op_wr) valid[set] <= 1'b1;
          state <= op_wr ? S_RESP : S_FILL;
        end
        S_FILL: if (!bus.mem_req) begin
          bus.mem_req <= 1'b1;
          bus.mem_we <= 1'b0;
          bus.mem_addr <= a;
        end else if (bus.mem_ready) begin
          bus.mem_req <= 1'b0;
          valid[set] <= 1'b1;
          dirty[set] <= 1'b0;
          bus.data_L2_L1 <= bus.mem_rdata;
          state <= S_RESP;
        end
        S_RESP: state <= S_HOLD;
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef L2_STAT_EN
  // Saturating hit/miss counters, one count per lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit <= '0;
      stat_miss <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit && stat_hit != '1) stat_hit <= stat_hit + 32'd1;
      if (!hit && stat_miss != '1) stat_miss <= stat_miss + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_l2_l1_responder.sv
// tb_l2_l1_responder: directed scoreboard bench for l2_l1_responder (L2_STAT_EN optional)
module tb_l2_l1_responder;
  localparam int LAT = 4;
  localparam logic [127:0] P5 = {16{8'hA5}};
  localparam logic [127:0] W1 = 128'h1234;
  localparam logic [127:0] W2 = 128'h5678_9ABC;
  localparam logic [127:0] D1 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] Q = 128'h0F0F_F0F0_1357_2468_ACE0_BDF1_9999_7777;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  int ready_cnt = 0;
  int txn_cnt = 0;
  int wcnt = 0;
  logic exp_chk [$];
  logic [127:0] exp_dat [$];
  logic exp_mwe [$];
  logic [25:0] exp_maddr [$];
  logic [127:0] exp_mwdata [$];
  logic [127:0] mm [logic [25:0]];
  l2_l1_responder_if #(.LINE_W(128), .ADDR_W(26)) bus ();
`ifdef L2_STAT_EN
  logic [31:0] stat_hit, stat_miss;
`endif
  l2_l1_responder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef L2_STAT_EN
    ,
    .stat_hit(stat_hit),
    .stat_miss(stat_miss)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_mem(input logic we, input logic [25:0] addr, input logic [127:0] wd);
    exp_mwe.push_back(we);
    exp_maddr.push_back(addr);
    exp_mwdata.push_back(wd);
  endtask
  // L1 response scoreboard: every ready pulse pops one expectation
  always @(negedge clk) begin
    if (bus.ready_L2_L1) begin
      ready_cnt++;
      if (exp_chk.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL l1_unexpected_ready observed=1 expected=0");
      end else begin
        logic c;
        logic [127:0] d;
        c = exp_chk.pop_front();
        d = exp_dat.pop_front();
        if (c) chk("l1_data", bus.data_L2_L1, d);
      end
    end
  end
  // Memory model: answers each request LAT cycles after it is seen, checking it against the expected queue
  always @(negedge clk) begin
    bus.mem_ready = 1'b0;
    if (rst) wcnt = 0;
    else if (bus.mem_req) begin
      if (wcnt == LAT - 1) begin
        wcnt = 0;
        bus.mem_ready = 1'b1;
        if (exp_mwe.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL mem_unexpected observed=%0h expected=none", bus.mem_addr);
        end else begin
          logic we;
          logic [25:0] ad;
          logic [127:0] wd;
          we = exp_mwe.pop_front();
          ad = exp_maddr.pop_front();
          wd = exp_mwdata.pop_front();
          chk("mem_we", bus.mem_we, we);
          chk("mem_addr", bus.mem_addr, ad);
          if (we) chk("mem_wdata", bus.mem_wdata, wd);
        end
        if (bus.mem_we) mm[bus.mem_addr] = bus.mem_wdata;
        else bus.mem_rdata = mm.exists(bus.mem_addr) ? mm[bus.mem_addr] : P5;
      end else wcnt++;
    end
  end
  // One L1 transaction, request held through the ready cycle and the following hold cycle
  task automatic l1(input logic wr, input logic [20:0] tag, input logic [4:0] idx, input logic [127:0] d,
                    input logic cd, input logic [127:0] ed, input int elat, input logic nomem);
    int lat = 0;
    int mcyc = 0;
    exp_chk.push_back(cd);
    exp_dat.push_back(ed);
    txn_cnt++;
    @(negedge clk);
    bus.read_L1_L2 = !wr;
    bus.write_L1_L2 = wr;
    bus.index_L1_L2 = idx;
    bus.tag_L1_L2 = wr ? ~tag : tag;
    bus.write_tag_L1_L2 = wr ? tag : ~tag;
    bus.data_L1_L2 = d;
    do begin
      @(negedge clk);
      lat++;
      if (bus.mem_req) mcyc++;
    end while (!bus.ready_L2_L1 && lat < 200);
    chk("ready_seen", bus.ready_L2_L1, 1);
    if (elat > 0) chk("latency", lat, elat);
    if (nomem) chk("no_mem_req", mcyc, 0);
    @(posedge clk);
    @(negedge clk);
    bus.read_L1_L2 = 0;
    bus.write_L1_L2 = 0;
    repeat (3) @(posedge clk);
    #1 chk("ready_pulses", ready_cnt, txn_cnt);
  endtask
  initial begin
    int n;
    bus.read_L1_L2 = 0;
    bus.write_L1_L2 = 0;
    bus.index_L1_L2 = 0;
    bus.tag_L1_L2 = 0;
    bus.write_tag_L1_L2 = 0;
    bus.data_L1_L2 = 0;
    bus.mem_rdata = 0;
    bus.mem_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.ready_L2_L1, 0);
    chk("rst_data", bus.data_L2_L1, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
`ifdef L2_STAT_EN
    chk("rst_stat_hit", stat_hit, 0);
    chk("rst_stat_miss", stat_miss, 0);
`endif
    rst = 0;
    push_mem(0, 26'h23, 0);
    l1(0, 21'h1, 5'd3, 0, 1, P5, 0, 0);
    l1(0, 21'h1, 5'd3, 0, 1, P5, 2, 1);
    l1(1, 21'h10, 5'd1, W1, 0, 0, 2, 1);
    l1(0, 21'h10, 5'd1, 0, 1, W1, 2, 1);
    l1(1, 21'h0, 5'd5, D1, 0, 0, 2, 1);
    mm[26'h85] = Q;
    push_mem(1, 26'h005, D1);
    push_mem(0, 26'h085, 0);
    l1(0, 21'h4, 5'd5, 0, 1, Q, 0, 0);
    push_mem(0, 26'h005, 0);
    l1(0, 21'h0, 5'd5, 0, 1, D1, 0, 0);
    l1(0, 21'h0, 5'd5, 0, 1, D1, 2, 1);
    @(negedge clk);
    bus.read_L1_L2 = 1;
    bus.tag_L1_L2 = 21'h2;
    bus.index_L1_L2 = 5'd0;
    bus.write_tag_L1_L2 = ~21'h2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_req && n < 50);
    chk("fill_mem_req", bus.mem_req, 1);
    rst = 1;
    bus.read_L1_L2 = 0;
    @(negedge clk);
    chk("abort_mem_req", bus.mem_req, 0);
    chk("abort_ready", bus.ready_L2_L1, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("abort_no_pulse", ready_cnt, txn_cnt);
    push_mem(0, 26'h40, 0);
    l1(0, 21'h2, 5'd0, 0, 1, P5, 0, 0);
    l1(0, 21'h2, 5'd0, 0, 1, P5, 2, 1);
    l1(0, 21'h2, 5'd0, 0, 1, P5, 2, 1);
    l1(1, 21'h10, 5'd1, W2, 0, 0, 2, 1);
    l1(0, 21'h10, 5'd1, 0, 1, W2, 2, 1);
`ifdef L2_STAT_EN
    chk("stat_hit", stat_hit, 3);
    chk("stat_miss", stat_miss, 2);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("stat_hit_clr", stat_hit, 0);
    chk("stat_miss_clr", stat_miss, 0);
`endif
    chk("l1_queue_drained", exp_chk.size(), 0);
    chk("mem_queue_drained", exp_mwe.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
